raizing_rom_arbiter: RTL and testbench
======================================

# raizing_rom_arbiter

Parametrised SDRAM read arbiter that multiplexes NSLOT ROM request slots onto one SDRAM bank port. Each slot has a one-entry tagged data register, so a slot whose address does not change is served without new SDRAM traffic. It is the generalised successor to the fixed per-slot wiring between the video, CPU and sound ROM ports and the bank interface. It serves 16-bit or 32-bit slots with per-slot base offsets, a fixed-priority slot and round-robin among the rest.

## Interface
- NSLOT, 4: number of request slots, 2..8.
- AW, 22: slot address width. Slot addresses are in DW-bit words.
- DW, 32: slot data width, 16 or 32. A 32-bit word is two SDRAM beats.
- PRIO_SLOT, 0: index of the slot that always wins arbitration when pending. A value ≥ NSLOT disables fixed priority.
- OFFSETS, 0: flat NSLOT*22-bit vector. Slot i uses bits [22*i+21:22*i] as its base in the bank, in 16-bit units.

- CLK  in  1  bank clock (96 MHz domain); sole clock.
- RESET  in  1  synchronous, active-high reset.
- SLOT_CS  in  NSLOT  per-slot read request, level sensitive.
- SLOT_ADDR  in  NSLOT*AW  per-slot word address; slot i uses [AW*i+AW-1:AW*i].
- SLOT_OK  out  NSLOT  data valid for the current SLOT_ADDR.
- SLOT_DOUT  out  NSLOT*DW  per-slot data.
- BA_ADDR  out  22  bank address, 16-bit units.
- BA_RD  out  1  bank read request.
- BA_ACK  in  1  bank accepted request.
- BA_DOK  in  1  DATA_READ valid this cycle (one beat).
- BA_RDY  in  1  final beat of the burst.
- DATA_READ  in  16  bank read data.

## Operation
- Per-slot state:
  - TAG[i] (AW bits), VALID[i], DATA[i] (DW bits).
  - HIT[i] = VALID[i] & (TAG[i] == SLOT_ADDR[i]), evaluated combinationally.
  - SLOT_OK[i] = SLOT_CS[i] & HIT[i], combinational.
  - SLOT_DOUT[i] = DATA[i], registered.
  - PEND[i] = SLOT_CS[i] & ~HIT[i] & not currently in service.
- FSM states: IDLE, REQ, DATA.
- IDLE:
  - If any slot is pending, grant one. PRIO_SLOT wins if pending.
  - Otherwise the grant goes round-robin, starting at LAST+1 mod NSLOT, where LAST is the previous grantee.
  - On grant, latch GNT, latch ATAG = SLOT_ADDR[GNT], and go to REQ.
- REQ:
  - BA_RD = 1.
  - BA_ADDR = OFFSET[GNT] + (ATAG << (DW==32 ? 1 : 0)), truncated to 22 bits.
  - On BA_ACK, go to DATA. BA_RD drops in the cycle after ACK.
- DATA:
  - First BA_DOK writes DATA[GNT][15:0].
  - Second BA_DOK (DW=32) writes DATA[GNT][31:16].
  - At the cycle of BA_RDY plus the last required beat: TAG[GNT] = ATAG, VALID[GNT] = 1, LAST = GNT, go to IDLE.
  - Extra DOK beats beyond the required count are ignored.
- Address change during service: the fill is still tagged with ATAG. If SLOT_ADDR no longer equals ATAG, HIT stays 0 and the slot is re-requested from IDLE.
- SLOT_CS dropping during service: the transaction completes and the entry is still written.
- During a fill, VALID[GNT] is held 0 from grant until the write, so no stale half-word is ever reported OK.

## Timing
- Reset values:
  - State IDLE.
  - BA_RD = 0, BA_ADDR = 0.
  - All VALID = 0, so SLOT_OK = 0.
  - SLOT_DOUT = 0, LAST = NSLOT-1.
  - RESET mid-transaction aborts immediately. Later bank beats are ignored until the next grant.
- Hit latency: SLOT_OK follows SLOT_CS/SLOT_ADDR in the same cycle (0 cycles).
- Miss latency:
  - IDLE→REQ takes 1 cycle.
  - The wait for BA_ACK is bank dependent.
  - SLOT_OK rises the cycle after the final beat.
- Back-to-back: the next grant occurs in the IDLE cycle immediately after the fill. There is at most one idle cycle between requests.
- Simultaneous pending slots: exactly one grant per IDLE cycle. A non-priority slot waits at most NSLOT-1 grants, plus any PRIO_SLOT grants.
- BA_ADDR and GNT are stable from REQ entry until the return to IDLE.

## Test plan
- Reset, then CS0=1, ADDR0=0x10, DW=32, OFFSET0=0x100000:
  - BA_RD with BA_ADDR=0x100020.
  - Beats 0x1234 then 0xABCD.
  - Next cycle SLOT_OK[0]=1 and DOUT0=0xABCD1234.
  - Holding the address gives no further BA_RD.
- Slots 1, 2, 3 pending together with PRIO_SLOT=0 idle and LAST=1: grant order is 2, 3, 1.
- Slot 0 raised while slot 2 is in service: slot 0 is granted in the next IDLE, ahead of pending slot 3.
- Slot 1 ADDR changes 0x20→0x21 during DATA: entry is tagged 0x20, OK stays 0, and a second BA_RD is issued with the address for 0x21.
- RESET asserted during DATA after one beat:
  - BA_RD=0 and all OK=0.
  - Trailing DOK/RDY are ignored.
  - A fresh request completes with correct data.
- DW=16, NSLOT=8, OFFSET7=0x3FFFFF, ADDR7=1: BA_ADDR wraps to 0x000000. A single beat with RDY sets OK.

Source files
------------

// File: rtl/raizing_rom_arbiter.sv
// raizing_rom_arbiter
// Shares one SDRAM bank read port between NSLOT ROM request slots.
// Each slot keeps a one-entry tagged data register, so a slot that keeps
// the same address is answered from the register without bank traffic.
// One slot can be given fixed priority; the rest take turns round-robin.
module raizing_rom_arbiter #(
    parameter int                   NSLOT     = 4,
    parameter int                   AW        = 22,
    parameter int                   DW        = 32,
    parameter int                   PRIO_SLOT = 0,
    parameter logic [NSLOT*22-1:0]  OFFSETS   = '0
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [NSLOT-1:0]        SLOT_CS,
    input  logic [NSLOT*AW-1:0]     SLOT_ADDR,
    output logic [NSLOT-1:0]        SLOT_OK,
    output logic [NSLOT*DW-1:0]     SLOT_DOUT,
    output logic [21:0]             BA_ADDR,
    output logic                    BA_RD,
    input  logic                    BA_ACK,
    input  logic                    BA_DOK,
    input  logic                    BA_RDY,
    input  logic [15:0]             DATA_READ
);

    localparam int         GW       = $clog2(NSLOT);
    localparam int         SHIFT    = (DW == 32) ? 1 : 0;
    localparam logic [1:0] NB       = (DW == 32) ? 2'd2 : 2'd1;
    localparam bit         PRIO_EN  = (PRIO_SLOT < NSLOT);
    localparam int         PRIO_IDX = PRIO_EN ? PRIO_SLOT : 0;

    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

    state_t             state_q;
    logic [GW-1:0]      gnt_q;
    logic [GW-1:0]      last_q;
    logic [AW-1:0]      atag_q;
    logic [1:0]         beat_q;
    logic               ba_rd_q;
    logic [21:0]        ba_addr_q;
    logic [AW-1:0]      tag_q  [NSLOT];
    logic [NSLOT-1:0]   valid_q;
    logic [DW-1:0]      data_q [NSLOT];

    logic [NSLOT-1:0]   hit;
    logic [NSLOT-1:0]   pend;
    logic               pickValid;
    logic [GW-1:0]      pickIdx;
    logic [GW-1:0]      candIdx;
    int                 cand;
    logic [AW-1:0]      pickAddr;
    logic [21:0]        reqAddr;
    logic               dokTaken;
    logic [1:0]         beatsNow;

    // Places one 16-bit bank beat into the low or high half of a slot word.
    function automatic logic [DW-1:0] mergeBeat(input logic [DW-1:0] cur,
                                                input logic [15:0]   beat,
                                                input logic          upper);
        logic [DW-1:0] res;
        res = cur;
        if (upper)
            res[DW-1 -: 16] = beat;
        else
            res[15:0] = beat;
        return res;
    endfunction

    // Per-slot hit and pending flags; the slot being filled is never pending.
    always_comb begin
        hit  = '0;
        pend = '0;
        for (int i = 0; i < NSLOT; i++) begin
            hit[i]  = valid_q[i] && (tag_q[i] == SLOT_ADDR[AW*i +: AW]);
            pend[i] = SLOT_CS[i] && !hit[i] &&
                      !((state_q != IDLE) && (gnt_q == GW'(i)));
        end
    end

    // Grant choice: priority slot first, else first pending slot after LAST.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = '0;
        cand      = 0;
        candIdx   = '0;
        for (int k = NSLOT; k >= 1; k--) begin
            cand    = (int'(last_q) + k) % NSLOT;
            candIdx = GW'(cand);
            if (pend[candIdx]) begin
                pickValid = 1'b1;
                pickIdx   = candIdx;
            end
        end
        if (PRIO_EN && pend[PRIO_IDX]) begin
            pickValid = 1'b1;
            pickIdx   = GW'(PRIO_IDX);
        end
    end

    // Bank address of the chosen slot: its base plus the word address in 16-bit units.
    always_comb begin
        pickAddr = SLOT_ADDR[AW*pickIdx +: AW];
        reqAddr  = OFFSETS[22*pickIdx +: 22] + 22'({1'b0, pickAddr} << SHIFT);
    end

    // Beat bookkeeping: how many required beats have arrived including this cycle.
    always_comb begin
        dokTaken = BA_DOK && (beat_q < NB);
        beatsNow = beat_q + {1'b0, dokTaken};
    end

    // Arbitration FSM, bank request registers and per-slot tagged entries.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            last_q    <= GW'(NSLOT - 1);
            atag_q    <= '0;
            beat_q    <= '0;
            ba_rd_q   <= 1'b0;
            ba_addr_q <= '0;
            valid_q   <= '0;
            for (int i = 0; i < NSLOT; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (pickValid) begin
                        gnt_q            <= pickIdx;
                        atag_q           <= pickAddr;
                        valid_q[pickIdx] <= 1'b0;
                        beat_q           <= '0;
                        ba_rd_q          <= 1'b1;
                        ba_addr_q        <= reqAddr;
                        state_q          <= REQ;
                    end
                end
                REQ: begin
                    if (BA_ACK) begin
                        ba_rd_q <= 1'b0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (dokTaken) begin
                        data_q[gnt_q] <= mergeBeat(data_q[gnt_q], DATA_READ, beat_q == 2'd1);
                        beat_q        <= beatsNow;
                    end
                    if (BA_RDY && (beatsNow == NB)) begin
                        tag_q[gnt_q]   <= atag_q;
                        valid_q[gnt_q] <= 1'b1;
                        last_q         <= gnt_q;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output mapping of the registered slot data.
    always_comb begin
        SLOT_DOUT = '0;
        for (int i = 0; i < NSLOT; i++)
            SLOT_DOUT[DW*i +: DW] = data_q[i];
    end

    assign SLOT_OK = SLOT_CS & hit;
    assign BA_RD   = ba_rd_q;
    assign BA_ADDR = ba_addr_q;

endmodule

// File: tb/tb_raizing_rom_arbiter.sv
// Testbench for raizing_rom_arbiter.
// Instance A: 4 slots of 32-bit data with distinct bases, slot 0 prioritised.
// Instance B: 8 slots of 16-bit data, slot 7 based at the top of the bank.
// Both share the bank response signals; only one instance is ever busy.
module tb_raizing_rom_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         baAck, baDok, baRdy;
    logic [15:0]  dataRead;

    logic [3:0]   csA;
    logic [87:0]  addrA;
    logic [3:0]   okA;
    logic [127:0] doutA;
    logic [21:0]  baAddrA;
    logic         baRdA;

    logic [7:0]   csB;
    logic [175:0] addrB;
    logic [7:0]   okB;
    logic [127:0] doutB;
    logic [21:0]  baAddrB;
    logic         baRdB;

    logic         useB;
    logic         baRdMux;
    logic [21:0]  baAddrMux;

    // Reference model state for instance A
    logic         aCs   [4];
    logic [21:0]  aAddr [4];
    logic [21:0]  offA  [4];
    logic [21:0]  mTag  [4];
    logic         mValid[4];
    logic [31:0]  mData [4];
    int           mLast;

    int checks = 0;
    int passed = 0;
    int failed = 0;

    raizing_rom_arbiter #(
        .NSLOT(4), .AW(22), .DW(32), .PRIO_SLOT(0),
        .OFFSETS({22'h3FFFF0, 22'h200000, 22'h000400, 22'h100000})
    ) dutA (
        .CLK(clk), .RESET(rst), .SLOT_CS(csA), .SLOT_ADDR(addrA),
        .SLOT_OK(okA), .SLOT_DOUT(doutA), .BA_ADDR(baAddrA), .BA_RD(baRdA),
        .BA_ACK(baAck), .BA_DOK(baDok), .BA_RDY(baRdy), .DATA_READ(dataRead)
    );

    raizing_rom_arbiter #(
        .NSLOT(8), .AW(22), .DW(16), .PRIO_SLOT(0),
        .OFFSETS({22'h3FFFFF, 154'h0})
    ) dutB (
        .CLK(clk), .RESET(rst), .SLOT_CS(csB), .SLOT_ADDR(addrB),
        .SLOT_OK(okB), .SLOT_DOUT(doutB), .BA_ADDR(baAddrB), .BA_RD(baRdB),
        .BA_ACK(baAck), .BA_DOK(baDok), .BA_RDY(baRdy), .DATA_READ(dataRead)
    );

    assign baRdMux   = useB ? baRdB   : baRdA;
    assign baAddrMux = useB ? baAddrB : baAddrA;

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < 4; i++) begin
            csA[i]            = aCs[i];
            addrA[22*i +: 22] = aAddr[i];
        end
        #1;
    endtask

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            mValid[i] = 1'b0;
            mTag[i]   = '0;
            mData[i]  = '0;
        end
        mLast = 3;
    endtask

    task automatic modelFill(input int g, input logic [21:0] tag, input logic [31:0] word);
        mTag[g]   = tag;
        mValid[g] = 1'b1;
        mData[g]  = word;
        mLast     = g;
    endtask

    function automatic int modelPick();
        logic p [4];
        int   idx;
        for (int i = 0; i < 4; i++)
            p[i] = aCs[i] && !(mValid[i] && (mTag[i] == aAddr[i]));
        if (p[0]) return 0;
        for (int k = 1; k <= 4; k++) begin
            idx = (mLast + k) % 4;
            if (p[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [21:0] expAddrA(input int g);
        logic [31:0] full;
        full = 32'(offA[g]) + (32'(aAddr[g]) << 1);
        return full[21:0];
    endfunction

    task automatic checkOutput();
        logic expOk;
        for (int i = 0; i < 4; i++) begin
            expOk = aCs[i] && mValid[i] && (mTag[i] == aAddr[i]);
            checkEq($sformatf("ok%0d", i), okA[i], expOk);
            checkEq($sformatf("dout%0d", i), doutA[32*i +: 32], mData[i]);
        end
    endtask

    task automatic waitReq(input logic [21:0] expAddr, output int waited);
        logic got;
        got    = 1'b0;
        waited = 0;
        while (!got && waited < 40) begin
            @(negedge clk);
            waited++;
            if (baRdMux) got = 1'b1;
        end
        checkEq("ba_rd_seen", got, 1'b1);
        if (got) checkEq("ba_addr", baAddrMux, expAddr);
    endtask

    task automatic ackReq();
        int d;
        d = $urandom_range(0, 2);
        repeat (d) @(negedge clk);
        checkEq("ba_rd_hold", baRdMux, 1'b1);
        baAck = 1'b1;
        @(negedge clk);
        baAck = 1'b0;
        checkEq("ba_rd_drop", baRdMux, 1'b0);
    endtask

    task automatic sendBeat(input logic [15:0] d, input logic last);
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) @(negedge clk);
        baDok    = 1'b1;
        baRdy    = last;
        dataRead = d;
        @(negedge clk);
        baDok    = 1'b0;
        baRdy    = 1'b0;
        dataRead = 16'($urandom);
    endtask

    task automatic serveA(input int g, output int waited);
        logic [21:0] tag;
        logic [15:0] lo, hi;
        tag = aAddr[g];
        lo  = 16'($urandom);
        hi  = 16'($urandom);
        waitReq(expAddrA(g), waited);
        ackReq();
        sendBeat(lo, 1'b0);
        sendBeat(hi, 1'b1);
        modelFill(g, tag, {hi, lo});
    endtask

    initial begin
        int w, g, n, rdCount;
        logic [15:0] lo, hi;

        offA[0] = 22'h100000; offA[1] = 22'h000400;
        offA[2] = 22'h200000; offA[3] = 22'h3FFFF0;
        rst = 1'b1; useB = 1'b0;
        baAck = 1'b0; baDok = 1'b0; baRdy = 1'b0; dataRead = '0;
        csB = '0; addrB = '0;
        for (int i = 0; i < 4; i++) begin
            aCs[i]   = 1'b1;
            aAddr[i] = '0;
        end
        modelReset();
        applyStimulus();
        repeat (3) @(negedge clk);

        // Reset state, with requests asserted so OK=0 is meaningful
        checkEq("reset_ba_rd", baRdA, 1'b0);
        checkEq("reset_ba_addr", baAddrA, 22'h0);
        checkEq("reset_ok", okA, 4'h0);
        checkEq("reset_dout", doutA, 128'h0);
        checkEq("reset_b_ba_rd", baRdB, 1'b0);
        for (int i = 0; i < 4; i++) aCs[i] = 1'b0;
        applyStimulus();
        rst = 1'b0;

        // Basic 32-bit miss on slot 0 with base offset
        $display("[TB] basic fill slot 0");
        aCs[0] = 1'b1; aAddr[0] = 22'h10;
        applyStimulus();
        waitReq(22'h100020, w);
        ackReq();
        sendBeat(16'h1234, 1'b0);
        sendBeat(16'hABCD, 1'b1);
        modelFill(0, 22'h10, 32'hABCD1234);
        checkEq("plan_ok0", okA[0], 1'b1);
        checkEq("plan_dout0", doutA[31:0], 32'hABCD1234);
        checkOutput();
        rdCount = 0;
        repeat (10) begin
            @(negedge clk);
            if (baRdA) rdCount++;
        end
        checkEq("no_refetch", rdCount, 0);

        // Round-robin order with LAST=1: expect 2, 3, 1
        $display("[TB] round-robin order");
        aCs[1] = 1'b1; aAddr[1] = 22'h05;
        applyStimulus();
        serveA(modelPick(), w);
        checkOutput();
        aAddr[1] = 22'h06;
        aCs[2] = 1'b1; aAddr[2] = 22'h07;
        aCs[3] = 1'b1; aAddr[3] = 22'h08;
        applyStimulus();
        for (int k = 0; k < 3; k++) begin
            g = modelPick();
            serveA(g, w);
            if (k > 0) checkEq("b2b_gap", w, 1);
            checkOutput();
        end

        // Priority slot raised during another slot's service
        $display("[TB] priority preemption");
        aAddr[2] = 22'h09; aAddr[3] = 22'h0A;
        applyStimulus();
        g = modelPick();
        waitReq(expAddrA(g), w);
        ackReq();
        aAddr[0] = 22'h11;
        applyStimulus();
        lo = 16'($urandom); hi = 16'($urandom);
        sendBeat(lo, 1'b0);
        sendBeat(hi, 1'b1);
        modelFill(g, aAddr[g], {hi, lo});
        checkOutput();
        serveA(modelPick(), w);
        checkEq("prio_gap", w, 1);
        checkOutput();
        serveA(modelPick(), w);
        checkOutput();

        // Address change during the data phase
        $display("[TB] address change during fill");
        aAddr[1] = 22'h20;
        applyStimulus();
        waitReq(expAddrA(1), w);
        ackReq();
        lo = 16'($urandom); hi = 16'($urandom);
        sendBeat(lo, 1'b0);
        aAddr[1] = 22'h21;
        applyStimulus();
        sendBeat(hi, 1'b1);
        modelFill(1, 22'h20, {hi, lo});
        checkEq("ok1_stale", okA[1], 1'b0);
        checkOutput();
        serveA(modelPick(), w);
        checkEq("readdr_ok1", okA[1], 1'b1);
        checkOutput();

        // Reset in the middle of a fill
        $display("[TB] reset during fill");
        aAddr[2] = 22'h30;
        applyStimulus();
        waitReq(expAddrA(2), w);
        ackReq();
        sendBeat(16'hBEEF, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        modelReset();
        checkEq("midrst_ba_rd", baRdA, 1'b0);
        checkEq("midrst_ok", okA, 4'h0);
        checkEq("midrst_ba_addr", baAddrA, 22'h0);
        for (int i = 0; i < 4; i++) aCs[i] = 1'b0;
        applyStimulus();
        rst = 1'b0;
        sendBeat(16'hCAFE, 1'b1);
        repeat (2) @(negedge clk);
        checkEq("trail_ba_rd", baRdA, 1'b0);
        checkOutput();
        aCs[2] = 1'b1;
        applyStimulus();
        serveA(modelPick(), w);
        checkOutput();

        // Randomised traffic against the model
        $display("[TB] random traffic");
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 4; i++) begin
                aCs[i] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 2) == 0) aAddr[i] = 22'h40 + 22'($urandom_range(0, 3));
            end
            applyStimulus();
            checkOutput();
            n = 0;
            while (modelPick() >= 0 && n < 8) begin
                serveA(modelPick(), w);
                checkOutput();
                n++;
            end
        end

        // 16-bit instance: bank address wraps at the top of the bank
        $display("[TB] 16-bit wrap on instance B");
        for (int i = 0; i < 4; i++) aCs[i] = 1'b0;
        applyStimulus();
        useB = 1'b1;
        csB[7] = 1'b1;
        addrB[7*22 +: 22] = 22'h1;
        #1;
        checkEq("b_ok_before", okB, 8'h00);
        waitReq(22'h000000, w);
        ackReq();
        sendBeat(16'h5A3C, 1'b1);
        checkEq("b_ok_after", okB, 8'h80);
        checkEq("b_dout7", doutB[7*16 +: 16], 16'h5A3C);
        rdCount = 0;
        repeat (5) begin
            @(negedge clk);
            if (baRdB) rdCount++;
        end
        checkEq("b_no_refetch", rdCount, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
